// File: rtl/cpu6502_pkg.sv
// Shared types for the reduced 6502 core: cycle states, addressing modes,
// operation classes, flag bit positions and the opcode decode table.
package cpu6502_pkg;

   typedef enum logic [2:0] {S_FETCH, S_ADL, S_ADH, S_IDX, S_PTRL, S_PTRH, S_EXEC, S_OP} state_t;
   typedef enum logic [3:0] {M_IMP, M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABX, M_ABY, M_IZX, M_IZY} mode_t;
   typedef enum logic [2:0] {C_NOP, C_LD, C_ST, C_ADC, C_CLC, C_SEC} opcls_t;
   typedef enum logic [1:0] {R_A, R_X, R_Y} reg_t;

   typedef struct packed {
      mode_t  mode;
      opcls_t cls;
      reg_t   rg;
   } dec_t;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 2;
   localparam int FLG_N = 3;

   localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDA_ZP = 8'hA5, OP_LDA_ZPX = 8'hB5, OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_LDA_ABX = 8'hBD, OP_LDA_ABY = 8'hB9, OP_LDA_IZX = 8'hA1, OP_LDA_IZY = 8'hB1;
   localparam logic [7:0] OP_LDX_IMM = 8'hA2, OP_LDX_ZP = 8'hA6, OP_LDX_ZPY = 8'hB6, OP_LDX_ABS = 8'hAE;
   localparam logic [7:0] OP_LDX_ABY = 8'hBE;
   localparam logic [7:0] OP_LDY_IMM = 8'hA0, OP_LDY_ZP = 8'hA4, OP_LDY_ZPX = 8'hB4, OP_LDY_ABS = 8'hAC;
   localparam logic [7:0] OP_LDY_ABX = 8'hBC;
   localparam logic [7:0] OP_STA_ZP = 8'h85, OP_STA_ZPX = 8'h95, OP_STA_ABS = 8'h8D, OP_STA_ABX = 8'h9D;
   localparam logic [7:0] OP_STA_ABY = 8'h99, OP_STA_IZX = 8'h81, OP_STA_IZY = 8'h91;
   localparam logic [7:0] OP_STX_ZP = 8'h86, OP_STX_ZPY = 8'h96, OP_STX_ABS = 8'h8E;
   localparam logic [7:0] OP_STY_ZP = 8'h84, OP_STY_ZPX = 8'h94, OP_STY_ABS = 8'h8C;
   localparam logic [7:0] OP_ADC_IMM = 8'h69, OP_ADC_ZP = 8'h65, OP_ADC_ZPX = 8'h75, OP_ADC_ABS = 8'h6D;
   localparam logic [7:0] OP_ADC_ABX = 8'h7D, OP_ADC_ABY = 8'h79, OP_ADC_IZX = 8'h61, OP_ADC_IZY = 8'h71;
   localparam logic [7:0] OP_CLC = 8'h18, OP_SEC = 8'h38;

   function automatic dec_t decode(input logic [7:0] i_op);
      dec_t d;
      d = '{M_IMP, C_NOP, R_A};
      case (i_op)
         OP_LDA_IMM: d = '{M_IMM, C_LD, R_A};
         OP_LDA_ZP:  d = '{M_ZP,  C_LD, R_A};
         OP_LDA_ZPX: d = '{M_ZPX, C_LD, R_A};
         OP_LDA_ABS: d = '{M_ABS, C_LD, R_A};
         OP_LDA_ABX: d = '{M_ABX, C_LD, R_A};
         OP_LDA_ABY: d = '{M_ABY, C_LD, R_A};
         OP_LDA_IZX: d = '{M_IZX, C_LD, R_A};
         OP_LDA_IZY: d = '{M_IZY, C_LD, R_A};
         OP_LDX_IMM: d = '{M_IMM, C_LD, R_X};
         OP_LDX_ZP:  d = '{M_ZP,  C_LD, R_X};
         OP_LDX_ZPY: d = '{M_ZPY, C_LD, R_X};
         OP_LDX_ABS: d = '{M_ABS, C_LD, R_X};
         OP_LDX_ABY: d = '{M_ABY, C_LD, R_X};
         OP_LDY_IMM: d = '{M_IMM, C_LD, R_Y};
         OP_LDY_ZP:  d = '{M_ZP,  C_LD, R_Y};
         OP_LDY_ZPX: d = '{M_ZPX, C_LD, R_Y};
         OP_LDY_ABS: d = '{M_ABS, C_LD, R_Y};
         OP_LDY_ABX: d = '{M_ABX, C_LD, R_Y};
         OP_STA_ZP:  d = '{M_ZP,  C_ST, R_A};
         OP_STA_ZPX: d = '{M_ZPX, C_ST, R_A};
         OP_STA_ABS: d = '{M_ABS, C_ST, R_A};
         OP_STA_ABX: d = '{M_ABX, C_ST, R_A};
         OP_STA_ABY: d = '{M_ABY, C_ST, R_A};
         OP_STA_IZX: d = '{M_IZX, C_ST, R_A};
         OP_STA_IZY: d = '{M_IZY, C_ST, R_A};
         OP_STX_ZP:  d = '{M_ZP,  C_ST, R_X};
         OP_STX_ZPY: d = '{M_ZPY, C_ST, R_X};
         OP_STX_ABS: d = '{M_ABS, C_ST, R_X};
         OP_STY_ZP:  d = '{M_ZP,  C_ST, R_Y};
         OP_STY_ZPX: d = '{M_ZPX, C_ST, R_Y};
         OP_STY_ABS: d = '{M_ABS, C_ST, R_Y};
         OP_ADC_IMM: d = '{M_IMM, C_ADC, R_A};
         OP_ADC_ZP:  d = '{M_ZP,  C_ADC, R_A};
         OP_ADC_ZPX: d = '{M_ZPX, C_ADC, R_A};
         OP_ADC_ABS: d = '{M_ABS, C_ADC, R_A};
         OP_ADC_ABX: d = '{M_ABX, C_ADC, R_A};
         OP_ADC_ABY: d = '{M_ABY, C_ADC, R_A};
         OP_ADC_IZX: d = '{M_IZX, C_ADC, R_A};
         OP_ADC_IZY: d = '{M_IZY, C_ADC, R_A};
         OP_CLC:     d = '{M_IMP, C_CLC, R_A};
         OP_SEC:     d = '{M_IMP, C_SEC, R_A};
         default:    d = '{M_IMP, C_NOP, R_A};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cpu6502_alu.sv
// Combinational binary adder with 6502 N/V/Z/C flags. Loads pass through
// with i_a=0 and i_cin=0 so the same Z/N logic serves them.
module cpu6502_alu (
   input  logic [7:0] i_a,
   input  logic [7:0] i_op,
   input  logic       i_cin,
   output logic [7:0] o_res,
   output logic       o_c,
   output logic       o_v,
   output logic       o_z,
   output logic       o_n
);
   logic [8:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_op} + {8'h00, i_cin};
   assign o_res = w_sum[7:0];
   assign o_c   = w_sum[8];
   // Overflow: operands agree in sign but the result does not
   assign o_v   = (i_a[7] == i_op[7]) && (w_sum[7] != i_a[7]);
   assign o_z   = (w_sum[7:0] == 8'h00);
   assign o_n   = w_sum[7];
endmodule

// File: rtl/cpu6502_core.sv
// Reduced NMOS-6502 core: one memory access per cycle, fixed cycle counts,
// loads/stores/ADC/CLC/SEC over the main addressing modes.
module cpu6502_core
   import cpu6502_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_di,
   output logic [7:0]  o_do,
   output logic        o_we,
   output logic [15:0] o_ab
);
   state_t      r_state, w_next;
   logic [15:0] r_pc, r_ea;
   logic [7:0]  r_a, r_x, r_y, r_ir, r_ptr, r_do;
   logic [3:0]  r_p;
   logic        r_we;
   dec_t        w_dec;
   logic [7:0]  w_idx, w_src, w_alu_a, w_res;
   logic        w_cin, w_c, w_v, w_z, w_n;

   // In FETCH the opcode is still on the bus, so decode it directly
   assign w_dec   = decode((r_state == S_FETCH) ? i_di : r_ir);
   assign w_idx   = (w_dec.mode inside {M_ZPY, M_ABY, M_IZY}) ? r_y : r_x;
   assign w_src   = (w_dec.rg == R_X) ? r_x : (w_dec.rg == R_Y) ? r_y : r_a;
   assign w_alu_a = (w_dec.cls == C_ADC) ? r_a : 8'h00;
   assign w_cin   = (w_dec.cls == C_ADC) && r_p[FLG_C];

   cpu6502_alu u_alu (
      .i_a(w_alu_a), .i_op(i_di), .i_cin(w_cin),
      .o_res(w_res), .o_c(w_c), .o_v(w_v), .o_z(w_z), .o_n(w_n)
   );

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH: w_next = (w_dec.mode inside {M_IMP, M_IMM}) ? S_OP : S_ADL;
         S_ADL: begin
            case (w_dec.mode)
               M_ZP:                 w_next = S_EXEC;
               M_ZPX, M_ZPY, M_IZX:  w_next = S_IDX;
               M_IZY:                w_next = S_PTRL;
               default:              w_next = S_ADH;
            endcase
         end
         S_ADH:   w_next = (w_dec.mode == M_ABS) ? S_EXEC : S_IDX;
         S_IDX:   w_next = (w_dec.mode == M_IZX) ? S_PTRL : S_EXEC;
         S_PTRL:  w_next = S_PTRH;
         S_PTRH:  w_next = (w_dec.mode == M_IZX) ? S_EXEC : S_IDX;
         default: w_next = S_FETCH;
      endcase
   end

   always_comb begin
      case (r_state)
         S_PTRL:  o_ab = {8'h00, r_ptr};
         S_PTRH:  o_ab = {8'h00, r_ptr + 8'd1};
         S_EXEC:  o_ab = r_ea;
         default: o_ab = r_pc;
      endcase
   end

   assign o_we = r_we;
   assign o_do = r_do;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_a     <= 8'h00;
         r_x     <= 8'h00;
         r_y     <= 8'h00;
         r_p     <= 4'h0;
         r_ir    <= 8'h00;
         r_ea    <= 16'h0000;
         r_ptr   <= 8'h00;
         r_we    <= 1'b0;
         r_do    <= 8'h00;
      end else begin
         r_state <= w_next;
         // Write strobe and data are set up one cycle ahead of the store EXEC
         r_we    <= (w_next == S_EXEC) && (w_dec.cls == C_ST);
         r_do    <= ((w_next == S_EXEC) && (w_dec.cls == C_ST)) ? w_src : 8'h00;
         case (r_state)
            S_FETCH: begin
               r_ir <= i_di;
               r_pc <= r_pc + 16'd1;
            end
            S_ADL: begin
               r_ea  <= {8'h00, i_di};
               r_ptr <= i_di;
               r_pc  <= r_pc + 16'd1;
            end
            S_ADH: begin
               r_ea[15:8] <= i_di;
               r_pc       <= r_pc + 16'd1;
            end
            S_IDX: begin
               case (w_dec.mode)
                  M_ZPX, M_ZPY: r_ea[7:0] <= r_ea[7:0] + w_idx;
                  M_IZX:        r_ptr     <= r_ptr + r_x;
                  default:      r_ea      <= r_ea + {8'h00, w_idx};
               endcase
            end
            S_PTRL: r_ea[7:0]  <= i_di;
            S_PTRH: r_ea[15:8] <= i_di;
            default: begin
               if (r_state == S_OP && w_dec.mode == M_IMM) r_pc <= r_pc + 16'd1;
               case (w_dec.cls)
                  C_LD: begin
                     case (w_dec.rg)
                        R_X:     r_x <= w_res;
                        R_Y:     r_y <= w_res;
                        default: r_a <= w_res;
                     endcase
                     r_p[FLG_Z] <= w_z;
                     r_p[FLG_N] <= w_n;
                  end
                  C_ADC: begin
                     r_a        <= w_res;
                     r_p[FLG_C] <= w_c;
                     r_p[FLG_V] <= w_v;
                     r_p[FLG_Z] <= w_z;
                     r_p[FLG_N] <= w_n;
                  end
                  C_CLC:   r_p[FLG_C] <= 1'b0;
                  C_SEC:   r_p[FLG_C] <= 1'b1;
                  default: ;
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cpu6502_core.sv
// Directed program bench for cpu6502_core with a flat 64 KiB memory model.
module tb_cpu6502_core;
   import cpu6502_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  di, dout;
   logic        we;
   logic [15:0] ab;
   logic [7:0]  mem [0:65535];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;
   assign di = mem[ab];

   cpu6502_core #(.RESET_PC(16'h0000)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_di(di), .o_do(dout), .o_we(we), .o_ab(ab)
   );

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock: bus sampled at the falling edge, write committed at the rising edge
   task automatic cycle();
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      w = we; a = ab; d = dout;
      @(posedge clk);
      if (w === 1'b1) mem[a] = d;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
      foreach (mem[i]) mem[i] = 8'h00;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state and SEC/LDA/ADC/CLC/ADC arithmetic
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8]} =
         {8'h38, 8'hA9, 8'h23, 8'h69, 8'h47, 8'h18, 8'h6D, 8'h00, 8'h13};
      mem[16'h1300] = 8'h69;
      #1;
      chk1 ("rst_we", we, 1'b0);
      chk16("rst_ab", ab, 16'h0000);
      chk8 ("rst_do", dout, 8'h00);
      chk8 ("rst_a", dut.r_a, 8'h00);
      chk8 ("rst_p", {4'h0, dut.r_p}, 8'h00);
      release_reset();
      run(2);
      chk1 ("sec_c", dut.r_p[FLG_C], 1'b1);
      run(4);
      chk8 ("adc1_a", dut.r_a, 8'h6B);
      run(6);
      chk8 ("adc2_a", dut.r_a, 8'hD4);
      chk1 ("adc2_n", dut.r_p[FLG_N], 1'b1);
      chk1 ("adc2_v", dut.r_p[FLG_V], 1'b1);
      chk1 ("adc2_c", dut.r_p[FLG_C], 1'b0);
      chk1 ("adc2_z", dut.r_p[FLG_Z], 1'b0);
      chk16("adc2_pc", dut.r_pc, 16'h0009);

      // abs,X load and abs,Y store within a page
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9]} =
         {8'hA2, 8'h05, 8'hA0, 8'h0B, 8'hBD, 8'h07, 8'h05, 8'h99, 8'h10, 8'h05};
      mem[16'h050C] = 8'h16;
      release_reset();
      run(14);
      chk8 ("absx_x", dut.r_x, 8'h05);
      chk8 ("absy_y", dut.r_y, 8'h0B);
      chk8 ("absy_mem", mem[16'h051B], 8'h16);

      // Same with page-crossing bases
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9]} =
         {8'hA2, 8'h05, 8'hA0, 8'h0B, 8'hBD, 8'hFE, 8'h05, 8'h99, 8'hFE, 8'h05};
      mem[16'h0603] = 8'h5A;
      release_reset();
      run(14);
      chk8 ("xpage_a", dut.r_a, 8'h5A);
      chk8 ("xpage_mem", mem[16'h0609], 8'h5A);
      chk8 ("xpage_nowrap", mem[16'h0509], 8'h00);

      // zp,X wraps inside page zero
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} =
         {8'hA2, 8'h23, 8'hB5, 8'h40, 8'h95, 8'hE9};
      mem[16'h0063] = 8'h43;
      release_reset();
      run(10);
      chk8 ("zpx_a", dut.r_a, 8'h43);
      chk8 ("zpx_mem", mem[16'h000C], 8'h43);
      chk8 ("zpx_nopage1", mem[16'h010C], 8'h00);

      // (zp,X) load and store
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} =
         {8'hA2, 8'h20, 8'hA1, 8'h40, 8'h81, 8'h60};
      {mem[16'h60], mem[16'h61], mem[16'h80], mem[16'h81]} = {8'h24, 8'h03, 8'h24, 8'h04};
      mem[16'h0324] = 8'h77;
      release_reset();
      run(14);
      chk8 ("izx_a", dut.r_a, 8'h77);
      chk8 ("izx_mem", mem[16'h0424], 8'h77);

      // (zp),Y load and store
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} =
         {8'hA0, 8'h33, 8'hB1, 8'h55, 8'h91, 8'h66};
      {mem[16'h55], mem[16'h56], mem[16'h66], mem[16'h67]} = {8'hB5, 8'h09, 8'hE0, 8'hA0};
      mem[16'h09E8] = 8'h67;
      release_reset();
      run(14);
      chk8 ("izy_a", dut.r_a, 8'h67);
      chk8 ("izy_mem", mem[16'hA113], 8'h67);

      // Load flags and an undefined opcode acting as NOP
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'hA9, 8'h00, 8'hA2, 8'h80, 8'hEA};
      release_reset();
      run(2);
      chk1 ("ld0_z", dut.r_p[FLG_Z], 1'b1);
      chk1 ("ld0_n", dut.r_p[FLG_N], 1'b0);
      run(2);
      chk8 ("ld80_x", dut.r_x, 8'h80);
      chk1 ("ld80_n", dut.r_p[FLG_N], 1'b1);
      chk1 ("ld80_z", dut.r_p[FLG_Z], 1'b0);
      run(2);
      chk16("nop_pc", dut.r_pc, 16'h0005);
      chk8 ("nop_x", dut.r_x, 8'h80);

      // Reset asserted during the ADH cycle of an absolute store
      hold_reset();
      {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'hA9, 8'h5A, 8'h8D, 8'h00, 8'h20};
      release_reset();
      run(4);
      chk8 ("pre_a", dut.r_a, 8'h5A);
      chk16("adh_ab", ab, 16'h0004);
      rst_n = 1'b0;
      #1;
      chk1 ("abort_we", we, 1'b0);
      chk16("abort_pc", dut.r_pc, 16'h0000);
      chk8 ("abort_a", dut.r_a, 8'h00);
      chk16("abort_ab", ab, 16'h0000);
      @(negedge clk);
      cycle();
      chk8 ("abort_nowrite", mem[16'h2000], 8'h00);
      rst_n = 1'b1;
      run(6);
      chk8 ("restart_mem", mem[16'h2000], 8'h5A);
      chk16("restart_pc", dut.r_pc, 16'h0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
